// File: rtl/multi_clk_time_manager.sv
// Emulated multi-clock time base: each emu_clk cycle advances emulated time by the
// smallest remaining interval among active channels and fires the channels that land on it.
module multi_clk_time_manager #(
  parameter int N_CLK          = 4,
  parameter int DT_WIDTH       = 24,
  parameter int T_WIDTH        = 48,
  parameter int DEFAULT_PERIOD = 1000,
  localparam int CW            = (N_CLK > 1) ? $clog2(N_CLK) : 1
) (
  input  logic                emu_clk,
  input  logic                rst,
  input  logic                emu_stall,
  input  logic [N_CLK-1:0]    chan_en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CW-1:0]       cfg_chan,
  input  logic [DT_WIDTH-1:0] cfg_period,
  input  logic [DT_WIDTH-1:0] cfg_phase,
  output logic [DT_WIDTH-1:0] dt_min,
  output logic [N_CLK-1:0]    clk_en,
  output logic [T_WIDTH-1:0]  t_emu,
  output logic                t_wrap
);

  localparam int NP = 1 << CW;
  localparam int SW = ((T_WIDTH > DT_WIDTH) ? T_WIDTH : DT_WIDTH) + 1;
  localparam logic [DT_WIDTH-1:0] DEF_PERIOD = DT_WIDTH'(DEFAULT_PERIOD);

  logic [DT_WIDTH-1:0] period_reg      [N_CLK];
  logic [DT_WIDTH-1:0] phase_reg       [N_CLK];
  logic [DT_WIDTH-1:0] rem_reg         [N_CLK];
  logic [DT_WIDTH-1:0] pend_period_reg [N_CLK];
  logic                pend_reg        [N_CLK];
  logic                en_q_reg        [N_CLK];
  logic [T_WIDTH-1:0]  t_emu_reg;
  logic                t_wrap_reg;

  logic [N_CLK-1:0]    active;
  logic [NP-1:0]       pend_pad;
  logic [DT_WIDTH-1:0] leaf [NP];
  logic [DT_WIDTH-1:0] tree [NP];
  logic                step;
  logic                cfg_acc;
  logic [DT_WIDTH-1:0] cfg_period_eff;
  logic [SW-1:0]       t_sum;

  // Unused tree leaves and out-of-range channel numbers are padded so they never win the
  // min and never report ready.
  for (genvar gi = 0; gi < NP; gi++) begin : g_leaf
    if (gi < N_CLK) begin : g_real
      assign active[gi]   = chan_en[gi] & en_q_reg[gi];
      assign leaf[gi]     = active[gi] ? rem_reg[gi] : '1;
      assign pend_pad[gi] = pend_reg[gi];
    end else begin : g_pad
      assign leaf[gi]     = '1;
      assign pend_pad[gi] = 1'b1;
    end
  end

  // Balanced min tree, reduced in place level by level.
  always_comb begin
    tree = leaf;
    for (int lvl = 0; lvl < CW; lvl++) begin
      for (int i = 0; i < NP / 2; i++) begin
        if (i < (NP >> (lvl + 1))) begin
          tree[i] = (tree[2*i+1] < tree[2*i]) ? tree[2*i+1] : tree[2*i];
        end
      end
    end
  end

  assign dt_min         = (!rst && !emu_stall && (|active)) ? tree[0] : '0;
  assign step           = (dt_min != '0);
  assign cfg_ready      = !rst && !pend_pad[cfg_chan];
  assign cfg_acc        = cfg_valid & cfg_ready;
  assign cfg_period_eff = (cfg_period == '0) ? DT_WIDTH'(1) : cfg_period;
  assign t_sum          = SW'(t_emu_reg) + SW'(dt_min);
  assign t_emu          = t_emu_reg;
  assign t_wrap         = t_wrap_reg;

  for (genvar gi = 0; gi < N_CLK; gi++) begin : g_chan
    logic cfg_hit;
    logic rise;

    assign clk_en[gi] = rst | (step & active[gi] & (rem_reg[gi] == dt_min));
    assign cfg_hit    = cfg_acc && (cfg_chan == CW'(gi));
    assign rise       = chan_en[gi] & ~en_q_reg[gi];

    always_ff @(posedge emu_clk) begin
      if (rst) begin
        period_reg[gi]      <= DEF_PERIOD;
        phase_reg[gi]       <= '0;
        rem_reg[gi]         <= DEF_PERIOD;
        pend_period_reg[gi] <= DEF_PERIOD;
        pend_reg[gi]        <= 1'b0;
        en_q_reg[gi]        <= 1'b0;
      end else begin
        en_q_reg[gi] <= chan_en[gi];

        if (rise) begin
          rem_reg[gi] <= (phase_reg[gi] != '0) ? phase_reg[gi] : period_reg[gi];
        end else if (step && active[gi]) begin
          if (clk_en[gi]) begin
            rem_reg[gi] <= pend_reg[gi] ? pend_period_reg[gi] : period_reg[gi];
          end else begin
            rem_reg[gi] <= rem_reg[gi] - dt_min;
          end
        end

        // A pending period lands either on the next fire or as soon as the channel is off.
        if (pend_reg[gi] && ((step && clk_en[gi]) || !chan_en[gi])) begin
          period_reg[gi] <= pend_period_reg[gi];
          pend_reg[gi]   <= 1'b0;
        end

        // cfg_hit implies pend_reg is clear, so it never collides with the commit above.
        if (cfg_hit) begin
          phase_reg[gi] <= cfg_phase;
          if (!chan_en[gi]) begin
            period_reg[gi] <= cfg_period_eff;
          end else begin
            pend_reg[gi]        <= 1'b1;
            pend_period_reg[gi] <= cfg_period_eff;
          end
        end
      end
    end
  end

  always_ff @(posedge emu_clk) begin
    if (rst) begin
      t_emu_reg  <= '0;
      t_wrap_reg <= 1'b0;
    end else if (step) begin
      t_emu_reg <= t_sum[T_WIDTH-1:0];
      if (|t_sum[SW-1:T_WIDTH]) begin
        t_wrap_reg <= 1'b1;
      end
    end
  end

endmodule
